// File: rtl/dqs_write_strober.sv
// Purpose: sequences the DQS pad controls (A/TS/RI) plus DQ_OE/BEAT for one write burst.
// Latency: DQS_TS rises after edge (accept + WL_CYC); the accept edge is WL+PRE+BL+POST cycles before READY returns.
// Backpressure: READY is low while a sequence runs; a WR_REQ in that window is discarded and sets sticky DROP.
module dqs_write_strober #(
    parameter int WL_CYC   = 4,
    parameter int PRE_CYC  = 2,
    parameter int POST_CYC = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       WR_REQ,
    input  logic       BL8,
    input  logic       RD_GATE,
    output logic       READY,
    output logic       DQS_A,
    output logic       DQS_TS,
    output logic       DQS_RI,
    output logic       DQ_OE,
    output logic [2:0] BEAT,
    output logic       DONE,
    output logic       DROP
);

    // The phase counter is shared by WAIT, PRE and POST; it must hold the
    // largest reload value, and is never smaller than a full BL8 burst.
    localparam int CNT_MAX = (WL_CYC > 8) ? WL_CYC : 8;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counters count down to zero, so each phase reloads with length-1.
    localparam logic [CW-1:0] WL_LOAD   = CW'((WL_CYC > 0) ? (WL_CYC - 1) : 0);
    localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_PRE   = 3'd2,
        S_BURST = 3'd3,
        S_POST  = 3'd4
    } state_e;

    // Sequencer state
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      beat_q, beat_d;
    logic            bl8_q, bl8_d;

    // Registered pad / datapath outputs
    logic            ready_q, ready_d;
    logic            dqs_a_q, dqs_a_d;
    logic            dqs_ts_q, dqs_ts_d;
    logic            dqs_ri_q, dqs_ri_d;
    logic            dq_oe_q, dq_oe_d;
    logic [2:0]      beat_out_q, beat_out_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;

    logic [2:0]      last_beat;

    // Burst length is frozen at acceptance; later BL8 changes are ignored.
    assign last_beat = bl8_q ? 3'd7 : 3'd3;

    // Next-state logic: walk IDLE -> WAIT -> PRE -> BURST -> POST -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        bl8_d   = bl8_q;
        unique case (state_q)
            S_IDLE: begin
                if (WR_REQ) begin
                    bl8_d  = BL8;
                    beat_d = 3'd0;
                    // A zero write latency skips WAIT and goes straight to preamble.
                    if (WL_CYC > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WL_LOAD;
                    end else begin
                        state_d = S_PRE;
                        cnt_d   = PRE_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_BURST;
                    beat_d  = 3'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BURST: begin
                if (beat_q == last_beat) begin
                    state_d = S_POST;
                    cnt_d   = POST_LOAD;
                    beat_d  = 3'd0;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            S_POST: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                beat_d  = 3'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every pad signal leaves a flop.
    always_comb begin
        ready_d    = (state_d == S_IDLE);
        dqs_ts_d   = (state_d == S_PRE) || (state_d == S_BURST) || (state_d == S_POST);
        dq_oe_d    = (state_d == S_BURST);
        // Strobe is high on even beats so the first edge after preamble rises.
        dqs_a_d    = dq_oe_d && !beat_d[0];
        beat_out_d = dq_oe_d ? beat_d : 3'd0;
        // Receive enable only while parked; never while driving or waiting to drive.
        dqs_ri_d   = ready_d && RD_GATE;
        done_d     = (state_q == S_POST) && (state_d == S_IDLE);
        drop_d     = drop_q || (WR_REQ && !ready_q);
    end

    // Sequencer registers; reset aborts any sequence in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= 3'd0;
            bl8_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            bl8_q   <= bl8_d;
        end
    end

    // Output registers; reset drops the pad to a quiet, idle-ready state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_q    <= 1'b1;
            dqs_a_q    <= 1'b0;
            dqs_ts_q   <= 1'b0;
            dqs_ri_q   <= 1'b0;
            dq_oe_q    <= 1'b0;
            beat_out_q <= 3'd0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            dqs_a_q    <= dqs_a_d;
            dqs_ts_q   <= dqs_ts_d;
            dqs_ri_q   <= dqs_ri_d;
            dq_oe_q    <= dq_oe_d;
            beat_out_q <= beat_out_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign READY  = ready_q;
    assign DQS_A  = dqs_a_q;
    assign DQS_TS = dqs_ts_q;
    assign DQS_RI = dqs_ri_q;
    assign DQ_OE  = dq_oe_q;
    assign BEAT   = beat_out_q;
    assign DONE   = done_q;
    assign DROP   = drop_q;

endmodule

// File: tb/tb_dqs_write_strober.sv
// Bench for dqs_write_strober: two instances (default timing, and WL=0/PRE=1)
// share one stimulus stream and are compared each cycle against a cycle-offset
// model of the write sequence, plus directed spot checks.
module tb_dqs_write_strober;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    logic WR_REQ  = 1'b0;
    logic BL8     = 1'b0;
    logic RD_GATE = 1'b0;

    logic       ready0, a0, ts0, ri0, oe0, done0, drop0;
    logic [2:0] beat0;
    logic       ready1, a1, ts1, ri1, oe1, done1, drop1;
    logic [2:0] beat1;

    wire [9:0] v0 = {ready0, ts0, a0, ri0, oe0, beat0, done0, drop0};
    wire [9:0] v1 = {ready1, ts1, a1, ri1, oe1, beat1, done1, drop1};

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Model: per instance, whether a write is in flight and how many edges
    // have passed since its accept edge.
    int m_wl   [2] = '{4, 0};
    int m_pre  [2] = '{2, 1};
    int m_post [2] = '{1, 1};
    bit m_busy [2];
    int m_k    [2];
    int m_bl   [2];
    bit m_done [2];
    bit m_drop [2];
    bit m_ri   [2];

    always #5 CLK = ~CLK;

    dqs_write_strober #(.WL_CYC(4), .PRE_CYC(2), .POST_CYC(1)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .WR_REQ(WR_REQ), .BL8(BL8), .RD_GATE(RD_GATE),
        .READY(ready0), .DQS_A(a0), .DQS_TS(ts0), .DQS_RI(ri0), .DQ_OE(oe0),
        .BEAT(beat0), .DONE(done0), .DROP(drop0)
    );

    dqs_write_strober #(.WL_CYC(0), .PRE_CYC(1), .POST_CYC(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .WR_REQ(WR_REQ), .BL8(BL8), .RD_GATE(RD_GATE),
        .READY(ready1), .DQS_A(a1), .DQS_TS(ts1), .DQS_RI(ri1), .DQ_OE(oe1),
        .BEAT(beat1), .DONE(done1), .DROP(drop1)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    // Expected outputs from the offset k since acceptance.
    function automatic logic [9:0] model_vec(int i);
        logic       rdy, ts, a, oe;
        logic [2:0] bt;
        int         ph;
        rdy = 1'b0; ts = 1'b0; a = 1'b0; oe = 1'b0; bt = 3'd0;
        if (!m_busy[i]) begin
            rdy = 1'b1;
        end else begin
            ph = m_k[i] - m_wl[i];
            if (ph >= 0) ts = 1'b1;
            ph = ph - m_pre[i];
            if (ph >= 0 && ph < m_bl[i]) begin
                oe = 1'b1;
                bt = 3'(ph);
                a  = ((ph % 2) == 0);
            end
        end
        return {rdy, ts, a, m_ri[i], oe, bt, m_done[i], m_drop[i]};
    endfunction

    task automatic model_edge(input int i);
        bit ready_now;
        ready_now = !m_busy[i];
        m_done[i] = 1'b0;
        if (WR_REQ && !ready_now) m_drop[i] = 1'b1;
        if (m_busy[i]) begin
            m_k[i]++;
            if (m_k[i] == m_wl[i] + m_pre[i] + m_bl[i] + m_post[i]) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
            end
        end else if (WR_REQ) begin
            m_busy[i] = 1'b1;
            m_k[i]    = 0;
            m_bl[i]   = BL8 ? 8 : 4;
        end
        m_ri[i] = !m_busy[i] && RD_GATE;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_k[i] = 0; m_done[i] = 1'b0;
            m_drop[i] = 1'b0; m_ri[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check("cyc_dut0", v0, model_vec(0));
        check("cyc_dut1", v1, model_vec(1));
    endtask

    // Asynchronous reset between clock edges; checked while still asserted.
    task automatic pulse_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("rst_dut0", v0, model_vec(0));
        check("rst_dut1", v1, model_vec(1));
        #2;
        RESET_N = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1]) && n < 60) begin
            step();
            n++;
        end
        check("idle_bound", 10'(n), 10'(n < 60 ? n : 0));
    endtask

    initial begin
        bit hist [$];
        int gaps, maxgap, run, s;
        bit seen_hi;

        #1 RESET_N = 1'b0;
        #1;
        model_reset();
        check("reset_dut0", v0, 10'h200);
        check("reset_dut1", v1, 10'h200);
        #6 RESET_N = 1'b1;

        // Default timing, BL4, accept at edge 10.
        while (edge_n < 9) step();
        WR_REQ = 1'b1; BL8 = 1'b0;
        step();
        WR_REQ = 1'b0; BL8 = 1'b1;
        check("e10_ready", 10'(ready0), 10'd0);
        while (edge_n < 21) begin
            step();
            if (edge_n == 13) check("e13_ts", 10'(ts0), 10'd0);
            if (edge_n == 14) check("e14_ts_a", {8'd0, ts0, a0}, 10'b10);
            if (edge_n == 15) check("e15_ts_a", {8'd0, ts0, a0}, 10'b10);
            if (edge_n >= 16 && edge_n <= 19)
                check("burst4", {5'd0, oe0, a0, beat0}, {5'd0, 1'b1, 1'(edge_n % 2 == 0), 3'(edge_n - 16)});
            if (edge_n == 20) check("e20_post", {7'd0, ts0, a0, oe0}, 10'b100);
            if (edge_n == 21) check("e21_done", {7'd0, ts0, done0, ready0}, 10'b011);
        end

        // BL8 with the same timing relative to acceptance.
        wait_idle();
        WR_REQ = 1'b1; BL8 = 1'b1;
        step();
        s = edge_n;
        WR_REQ = 1'b0; BL8 = 1'b0;
        while (edge_n < s + 15) begin
            step();
            if (edge_n - s >= 6 && edge_n - s <= 13)
                check("burst8", {6'd0, a0, beat0}, {6'd0, 1'((edge_n - s) % 2 == 0), 3'(edge_n - s - 6)});
            if (edge_n - s == 14) check("bl8_post", {8'd0, ts0, oe0}, 10'b10);
        end
        check("bl8_done", {8'd0, done0, ready0}, 10'b11);

        // Zero write latency: TS immediately after the accept edge.
        wait_idle();
        WR_REQ = 1'b1;
        step();
        WR_REQ = 1'b0;
        check("wl0_pre", {7'd0, ts1, a1, ready1}, 10'b100);
        step();
        check("wl0_first", {8'd0, a1, oe1}, 10'b11);

        // Request held high: back-to-back sequences, sticky DROP.
        wait_idle();
        check("drop_clear", {8'd0, drop0, drop1}, 10'b00);
        WR_REQ = 1'b1;
        step();
        BL8 = 1'($urandom_range(0, 1));
        step();
        check("drop_set", {8'd0, drop0, drop1}, 10'b11);
        repeat (40) begin
            BL8 = 1'($urandom_range(0, 1));
            step();
            hist.push_back(ts1);
        end
        WR_REQ = 1'b0;
        gaps = 0; maxgap = 0; run = 0; seen_hi = 1'b0;
        foreach (hist[j]) begin
            if (hist[j]) begin
                if (seen_hi && run > 0) begin
                    gaps++;
                    if (run > maxgap) maxgap = run;
                end
                seen_hi = 1'b1;
                run = 0;
            end else begin
                run++;
            end
        end
        check("held_gap", 10'(maxgap), 10'd1);
        check("held_gaps_seen", 10'(gaps >= 3), 10'd1);

        // Read gate: follows in idle, suppressed during a write.
        wait_idle();
        RD_GATE = 1'b1;
        step();
        check("ri_idle", 10'(ri0), 10'd1);
        WR_REQ = 1'b1;
        step();
        WR_REQ = 1'b0;
        check("ri_accept", 10'(ri0), 10'd0);
        s = 0;
        while (m_busy[0] && s < 40) begin
            step();
            s++;
            if (m_busy[0]) check("ri_write", 10'(ri0), 10'd0);
        end
        check("ri_resume", {8'd0, ri0, done0}, 10'b11);

        // Reset in the middle of a burst, then a full restart.
        WR_REQ = 1'b1; BL8 = 1'b1;
        step();
        WR_REQ = 1'b0;
        repeat (6) step();
        check("pre_rst_burst", {8'd0, a0, oe0}, 10'b11);
        pulse_reset();
        check("rst_mid", {5'd0, ts0, a0, oe0, ri0, ready0}, 10'b00001);
        WR_REQ = 1'b1; BL8 = 1'b0;
        step();
        WR_REQ = 1'b0;
        repeat (3) step();
        check("restart_wait", 10'(ts0), 10'd0);
        step();
        check("restart_ts", 10'(ts0), 10'd1);
        wait_idle();

        // Random traffic with occasional asynchronous resets.
        repeat (3000) begin
            WR_REQ  = ($urandom_range(0, 3) == 0);
            BL8     = 1'($urandom_range(0, 1));
            RD_GATE = 1'($urandom_range(0, 1));
            step();
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
